// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: state encoding, field widths and limits shared by the time-set controller.
package clock_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3} state_t;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam logic [HOUR_W-1:0] MAX_HOURS   = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MINUTES = 6'd59;
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: rising-edge detect plus hold auto-repeat, one-cycle evt per increment.
module btn_repeat #(
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic evt
);
    localparam int MX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CW = $clog2(MX + 1);
    logic          prev;
    logic [CW-1:0] cnt;
    logic          rise, rep;
    // cnt holds cycles remaining until the next repeat tick; 0 means idle until a fresh edge
    assign rise = btn & ~prev;
    assign rep  = btn & prev & (cnt == CW'(1));
    assign evt  = rise | rep;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            prev <= btn;
            cnt  <= (clr || !btn) ? '0 :
                    rise          ? CW'(REPEAT_DLY) :
                    rep           ? CW'(REPEAT_RATE) :
                    (cnt == '0)   ? '0 : cnt - 1'b1;
        end
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set sequencer with shadow hour/minute editing and a one-cycle load.
module clock_set_ctrl import clock_ctrl_pkg::*; #(
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 4,
    parameter int BLINK_DIV   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    output logic              run_en,
    output logic              load,
    output logic [HOUR_W-1:0] set_hours,
    output logic [MIN_W-1:0]  set_minutes,
    output logic [SEC_W-1:0]  set_seconds,
    output logic [1:0]        mode,
    output logic              blink
);
    localparam int BW = $clog2(BLINK_DIV + 1);
    state_t        state;
    logic          mode_prev, mode_evt, inc_evt, inc, adv, bwrap;
    logic [BW-1:0] bcnt;
    assign mode_evt    = btn_mode & ~mode_prev;
    assign adv         = mode_evt | (state == COMMIT);
    assign inc         = inc_evt & ~mode_evt;
    assign bwrap       = bcnt == BW'(BLINK_DIV - 1);
    assign mode        = state;
    assign set_seconds = '0;
    btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .clr(adv), .evt(inc_evt)
    );
    // states are numbered in visiting order, so advancing is +1 with COMMIT wrapping to RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            mode_prev   <= 1'b0;
            set_hours   <= '0;
            set_minutes <= '0;
            run_en      <= 1'b1;
            load        <= 1'b0;
            blink       <= 1'b0;
            bcnt        <= '0;
        end else begin
            mode_prev <= btn_mode;
            if (adv) begin
                state  <= state_t'(state + 2'd1);
                run_en <= state == COMMIT;
                load   <= state == SET_MIN;
                blink  <= 1'b0;
                bcnt   <= '0;
                if (state == RUN) begin
                    set_hours   <= (cur_hours > MAX_HOURS) ? '0 : cur_hours;
                    set_minutes <= (cur_minutes > MAX_MINUTES) ? '0 : cur_minutes;
                end
            end else if (state == SET_HR || state == SET_MIN) begin
                bcnt  <= bwrap ? '0 : bcnt + 1'b1;
                blink <= bwrap ? ~blink : blink;
                if (inc && state == SET_HR)
                    set_hours <= (set_hours == MAX_HOURS) ? '0 : set_hours + 1'b1;
                if (inc && state == SET_MIN)
                    set_minutes <= (set_minutes == MAX_MINUTES) ? '0 : set_minutes + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_clock_set_ctrl;
    localparam int S_MODE = 0, S_RUN = 1, S_LOAD = 2, S_H = 3, S_M = 4, S_BLINK = 5, S_LOADQ = 6;
    typedef struct {string name; int sel; int v;} chk_t;
    typedef struct {int h; int m;} ld_t;
    logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [4:0] cur_hours = '0, set_hours;
    logic [5:0] cur_minutes = '0, set_minutes, set_seconds;
    logic [1:0] mode;
    logic       run_en, load, blink;
    chk_t       q[$];
    ld_t        load_q[$];
    chk_t       c;
    ld_t        le;
    int         checks = 0, errors = 0, a;

    clock_set_ctrl dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .run_en(run_en), .load(load),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic int actual(input int sel);
        case (sel)
            S_MODE:  return int'(mode);
            S_RUN:   return int'(run_en);
            S_LOAD:  return int'(load);
            S_H:     return int'(set_hours);
            S_M:     return int'(set_minutes);
            S_BLINK: return int'(blink);
            default: return load_q.size();
        endcase
    endfunction

    always @(negedge clk) begin
        if (load === 1'b1) begin
            checks++;
            if (load_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load got %0d:%0d", set_hours, set_minutes);
            end else begin
                le = load_q.pop_front();
                if (set_hours !== 5'(le.h) || set_minutes !== 6'(le.m) || set_seconds !== 6'd0) begin
                    errors++;
                    $display("FAIL load_values got %0d:%0d:%0d want %0d:%0d:0",
                             set_hours, set_minutes, set_seconds, le.h, le.m);
                end
            end
        end
        while (q.size() > 0) begin
            c = q.pop_front();
            checks++;
            a = actual(c.sel);
            if (a !== c.v) begin
                errors++;
                $display("FAIL %s got %0d want %0d", c.name, a, c.v);
            end
        end
    end

    task automatic exp(input string n, input int s, input int v);
        q.push_back('{n, s, v});
    endtask

    task automatic step(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp("rst_mode", S_MODE, 0); exp("rst_run_en", S_RUN, 1); exp("rst_load", S_LOAD, 0);
        exp("rst_h", S_H, 0); exp("rst_m", S_M, 0); exp("rst_blink", S_BLINK, 0);
        step(0, 0);
        reset = 1'b0;
        step(0, 0);
        exp("run_blink", S_BLINK, 0);

        // capture 22:07, blink pattern, hour wrap
        cur_hours = 5'd22; cur_minutes = 6'd7;
        step(1, 0);
        exp("cap_mode", S_MODE, 1); exp("cap_run_en", S_RUN, 0); exp("cap_h", S_H, 22);
        exp("cap_m", S_M, 7); exp("hr_blink0", S_BLINK, 0);
        step(0, 0); exp("hr_blink1", S_BLINK, 0);
        step(0, 0); exp("hr_blink2", S_BLINK, 1);
        step(0, 0); exp("hr_blink3", S_BLINK, 1);
        step(0, 0); exp("hr_blink4", S_BLINK, 0);
        step(0, 1); exp("hr_inc1", S_H, 23);
        step(0, 0);
        step(0, 1); exp("hr_wrap", S_H, 0);
        step(0, 0);
        step(0, 1); exp("hr_inc3", S_H, 1);
        step(0, 0); exp("hr_min_kept", S_M, 7);

        // simultaneous mode and inc edges: mode wins
        step(1, 1);
        exp("both_mode", S_MODE, 2); exp("both_h", S_H, 1); exp("min_blink0", S_BLINK, 0);
        step(0, 0); exp("min_blink1", S_BLINK, 0);
        step(0, 0); exp("min_blink2", S_BLINK, 1);
        for (int i = 0; i < 30; i++) begin
            step(0, 1);
            step(0, 0);
        end
        exp("min_37", S_M, 37);

        // asynchronous reset mid-edit
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp("arst_mode", S_MODE, 0); exp("arst_run_en", S_RUN, 1); exp("arst_h", S_H, 0);
        exp("arst_m", S_M, 0); exp("arst_load", S_LOAD, 0); exp("arst_blink", S_BLINK, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0);

        // auto-repeat from 58: ticks at relative cycles 0, 8, 12, 16
        cur_hours = 5'd0; cur_minutes = 6'd58;
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        exp("rep_start", S_M, 58);
        for (int i = 0; i < 20; i++) begin
            step(0, 1);
            if (i == 0) exp("rep_c0", S_M, 59);
            if (i == 7) exp("rep_c7", S_M, 59);
            if (i == 8) exp("rep_c8", S_M, 0);
            if (i == 11) exp("rep_c11", S_M, 0);
            if (i == 12) exp("rep_c12", S_M, 1);
        end
        exp("rep_end", S_M, 2);
        step(0, 0);

        // commit 0:02
        load_q.push_back('{0, 2});
        step(1, 0);
        exp("c1_mode", S_MODE, 3); exp("c1_load", S_LOAD, 1); exp("c1_run_en", S_RUN, 0);
        step(0, 0);
        exp("c1_after_mode", S_MODE, 0); exp("c1_after_run", S_RUN, 1); exp("c1_after_load", S_LOAD, 0);

        // full sequence 10:15 plus 5 minute increments
        cur_hours = 5'd10; cur_minutes = 6'd15;
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1);
            step(0, 0);
        end
        load_q.push_back('{10, 20});
        step(1, 0);
        exp("c2_load", S_LOAD, 1); exp("c2_h", S_H, 10); exp("c2_m", S_M, 20);
        step(0, 0);
        exp("c2_run_en", S_RUN, 1); exp("c2_load_off", S_LOAD, 0);

        // increments ignored in RUN
        step(0, 1);
        step(0, 0);
        exp("run_inc_h", S_H, 10); exp("run_inc_m", S_M, 20); exp("run_mode", S_MODE, 0);
        step(0, 0);
        exp("loads_seen", S_LOADQ, 0);
        step(0, 0);
        step(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller that sequences the `Digital_Clock` counter through its run and set modes. It gates counting, holds shadow hour/minute values while the user edits them with two buttons, and issues a single load pulse that writes the edited time back into the counter. It sits between the debounced and synchronized button inputs and the clock counter's enable/load inputs.

## Interface
- `REPEAT_DLY`, default 8: cycles `btn_inc` must be held before auto-repeat starts.
- `REPEAT_RATE`, default 4: cycles between auto-repeat increments once repeating.
- `BLINK_DIV`, default 2: cycles per `blink` half-period in the set states.

- `clk`  in  1  single system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_mode`  in  1  mode button, already synchronized and debounced; active-high level.
- `btn_inc`  in  1  increment button, already synchronized and debounced; active-high level.
- `cur_hours`  in  5  live hours from the clock counter.
- `cur_minutes`  in  6  live minutes from the clock counter.
- `run_en`  out  1  count enable to the clock counter.
- `load`  out  1  one-cycle pulse that loads the `set_*` values.
- `set_hours`  out  5  shadow hours, range 0–23.
- `set_minutes`  out  6  shadow minutes, range 0–59.
- `set_seconds`  out  6  constant 0.
- `mode`  out  2  current state: 0 = RUN, 1 = SET_HR, 2 = SET_MIN, 3 = COMMIT.
- `blink`  out  1  display blink for the field being edited.

## Operation
- State machine RUN → SET_HR → SET_MIN → COMMIT → RUN.
  - A `btn_mode` rising edge advances RUN→SET_HR and SET_HR→SET_MIN.
  - SET_MIN→COMMIT also takes a `btn_mode` rising edge.
  - COMMIT→RUN is unconditional after one cycle.
- RUN → SET_HR:
  - Capture `cur_hours` into the shadow hours; a captured value ≥24 is stored as 0.
  - Capture `cur_minutes` into the shadow minutes; a captured value ≥60 is stored as 0.
- Edit states:
  - In SET_HR, each increment event adds 1 to shadow hours mod 24 (23→0).
  - In SET_MIN, each increment event adds 1 to shadow minutes mod 60 (59→0).
  - Increment events are ignored in RUN and COMMIT.
- An increment event is either:
  - a `btn_inc` rising edge, or
  - an auto-repeat tick: `btn_inc` held REPEAT_DLY cycles after its rising edge, then every REPEAT_RATE cycles while held.
- The hold counter clears when `btn_inc` is low or on any state change.
- If `btn_mode` and `btn_inc` both produce events in the same cycle, the mode edge wins and the increment is dropped.
- Outputs by state:
  - `run_en` = 1 only in RUN.
  - `load` = 1 only in COMMIT.
  - `blink` toggles every BLINK_DIV cycles in SET_HR and SET_MIN; it is 0 in RUN and COMMIT, and its phase restarts at 0 on each state entry.
- Reset (asynchronous, including mid-edit):
  - state = RUN, shadows = 0, `run_en` = 1, `load` = 0, `blink` = 0, edge/hold registers = 0.
  - No load is issued for the abandoned edit.

## Timing
- Edge detection: `btn` is high at this rising edge of `clk` and was low at the previous one.
- The state change or increment caused by an edge takes effect on that same `clk` edge; all outputs are registered.
- `run_en` falls in the cycle after the `btn_mode` edge is sampled in RUN.
- COMMIT lasts exactly one cycle: `load` is high for that one cycle, and `run_en` returns to 1 on the following cycle.
- `set_*` values are stable throughout the `load` cycle.
- A `btn_inc` held from its rising edge produces increments at relative cycles 0, REPEAT_DLY, REPEAT_DLY+REPEAT_RATE, REPEAT_DLY+2·REPEAT_RATE, and so on.
- `btn_mode` held high does not auto-repeat; only its rising edge counts.

## Structure
- Package `clock_ctrl_pkg` holds:
  - the state encoding (RUN/SET_HR/SET_MIN/COMMIT, 2 bits);
  - the constants MAX_HOURS = 23 and MAX_MINUTES = 59;
  - the field widths (hours 5 bits, minutes/seconds 6 bits).
- One sub-module, `btn_repeat`:
  - performs rising-edge detection plus the REPEAT_DLY/REPEAT_RATE hold counter;
  - takes a `clr` input driven on state change;
  - emits a single-cycle `evt` pulse.
- A separate edge detector handles `btn_mode`. All remaining logic (FSM, shadow registers, blink counter) is in the top module.

## Test plan
- Reset pulse mid-SET_MIN with shadow minutes = 37 → mode = 0, `run_en` = 1, shadows = 0, no `load` pulse ever seen.
- `cur_hours` = 22 at the mode edge, then 3 `btn_inc` edges in SET_HR → `set_hours` = 1 (22→23→0→1); minutes unchanged.
- SET_MIN with shadow = 58, `btn_inc` held 20 cycles (defaults) → increments at cycles 0, 8, 12, 16 → `set_minutes` = 2.
- Full sequence: capture 10:15, two mode edges after 5 minute increments → exactly one `load` cycle with hours = 10, minutes = 20, seconds = 0; `run_en` = 1 on the next cycle.
- `btn_mode` and `btn_inc` rising in the same cycle in SET_HR → state = SET_MIN, hours unchanged.
- `blink` in SET_HR with BLINK_DIV = 2 → pattern 0,0,1,1,0,0…; it is 0 in RUN and restarts at 0 on entry to SET_MIN.
